cpu_cmd_queue: RTL

Command front-end that sits directly upstream of the bus top (cpu → master → slave → cordic) and drives its wr/rd/byte/addr/wdata inputs.
- Buffers host register commands in a small FIFO.
- Issues them to the bus one at a time, as single-cycle pulses.
- Enforces a minimum spacing after writes and waits for rdata_v on reads, with a timeout.
- Returns read data to the host on a valid/ready response channel.

---
 rtl/cpu_cmd_queue_if.sv | 39 +++
 rtl/cpu_cmd_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_cmd_queue_if.sv
// Signal bundle between the host, cpu_cmd_queue and the bus top.
// The bus byte-lane mask is named bus_byte because "byte" is a reserved word.
interface cpu_cmd_queue_if;
    // host command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [3:0]  cmd_byte;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    // bus top side
    logic        wr;
    logic        rd;
    logic [3:0]  bus_byte;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        rdata_v;
    logic [31:0] rdata;
    // host response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_wr, cmd_byte, cmd_addr, cmd_wdata,
        input  rdata_v, rdata, rsp_ready,
        output cmd_ready, wr, rd, bus_byte, addr, wdata,
        output rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_byte, cmd_addr, cmd_wdata,
        output rdata_v, rdata, rsp_ready,
        input  cmd_ready, wr, rd, bus_byte, addr, wdata,
        input  rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/cpu_cmd_queue.sv
// Host command FIFO that issues single-cycle wr/rd pulses to the bus top and returns read data.
// Define WR_ACK_EN to make every write produce a zero-data response when its gap expires.
module cpu_cmd_queue #(
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH),
    parameter int WR_GAP     = 8,
    parameter int RD_TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst_n,
    cpu_cmd_queue_if.master bus
);

    localparam int CNT_MAX = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] GAP_LOAD = CW'(WR_GAP);
    localparam logic [CW-1:0] TMO_LOAD = CW'(RD_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD,
        RESP
    } state_e;

    typedef struct packed {
        logic        wr;
        logic [3:0]  mask;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          cmd_in;
    logic          push;
    logic          pop;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    state_e        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    cmd_t          cur_q,    cur_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q,  rsp_err_d;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cmd_in   = '{wr: bus.cmd_wr, mask: bus.cmd_byte, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        push     = bus.cmd_valid && (count_q != FULL_CNT);
        pop      = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    // ------------------------------------------------------------------
    // Issue / wait / response sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_d   = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (cur_q.wr) begin
                    cnt_d   = GAP_LOAD;
                    state_d = WAIT_WR;
                end else begin
                    cnt_d   = TMO_LOAD;
                    state_d = WAIT_RD;
                end
            end

            // The counter expires on the cycle it would reach zero, which spaces
            // consecutive write pulses WR_GAP + 2 cycles apart.
            WAIT_WR: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
`ifdef WR_ACK_EN
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
`else
                    state_d    = IDLE;
`endif
                end
            end

            // Returned data takes priority over a timeout expiring in the same cycle.
            WAIT_RD: begin
                if (bus.rdata_v) begin
                    rsp_data_d = bus.rdata;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end

            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready = (count_q != FULL_CNT);
    assign bus.wr        = (state_q == ISSUE) &&  cur_q.wr;
    assign bus.rd        = (state_q == ISSUE) && !cur_q.wr;
    assign bus.bus_byte  = cur_q.mask;
    assign bus.addr      = cur_q.addr;
    assign bus.wdata     = cur_q.wdata;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (count_q != '0) || (state_q != IDLE);

endmodule
